data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default `ADDRESS_SIZE, memory word address width.
REQ-002 SHALL have parameter DATA_SIZE, default `DATA_SIZE, memory word width.
REQ-003 SHALL have port clock  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  request from port 0 (core load/store) / port 1 (debug/DMA).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read, sampled with reqN.
REQ-007 SHALL have ports lock0/lock1  input  1  hold ownership after this grant (read-modify-write bursts).
REQ-008 SHALL have ports addr0/addr1  input  ADDRESS_SIZE  word address.
REQ-009 SHALL have ports wdata0/wdata1  input  DATA_SIZE  write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  command accepted this cycle (combinational).
REQ-011 SHALL have ports rvalid0/rvalid1  output  1  read data valid for port N.
REQ-012 SHALL have ports rdata0/rdata1  output  DATA_SIZE  read data; 0 when rvalidN = 0.
REQ-013 SHALL have ports mem_read/mem_write  output  1  memory strobes; never both 1.
REQ-014 SHALL have ports mem_address  output  ADDRESS_SIZE  and mem_data_in  output  DATA_SIZE  to memory.
REQ-015 SHALL have port mem_data_out  input  DATA_SIZE  registered memory read data (1-cycle latency).

Function
REQ-016 SHALL issue at most one command per cycle; gnt0 and gnt1 never both 1.
REQ-017 SHALL, when ungranted, drive mem_read = mem_write = 0, mem_address = 0, mem_data_in = 0.
REQ-018 SHALL, when granting port N, drive mem_address = addrN, mem_data_in = wdataN, mem_write = weN, mem_read = !weN in the same cycle.
REQ-019 SHALL have FSM states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-020 SHALL in IDLE arbitrate round-robin: single requester wins; both requesting -> port other than last_grant wins.
REQ-021 SHALL update register last_grant to N on every grant to N; reset value 1 (port 0 wins first contention).
REQ-022 SHALL go IDLE -> LOCKN on a grant to N with lockN = 1.
REQ-023 SHALL in LOCKN grant only port N when reqN = 1, ignoring the other port's request.
REQ-024 SHALL leave LOCKN -> IDLE on a cycle with reqN = 0 (no grant, other port not granted that cycle) or on a grant to N with lockN = 0.
REQ-025 SHALL, on read grant to N in cycle T, assert rvalidN in cycle T+1 only, with rdataN = mem_data_out.
REQ-026 SHALL track one in-flight read via registers rd_pending and rd_owner; back-to-back reads (any port mix) are fully pipelined at one per cycle.
REQ-027 SHALL not assert rvalid for write grants; a write in T+1 does not disturb the read return of a read granted in T.
REQ-028 SHALL keep gntN low whenever reqN = 0.

Reset
REQ-029 SHALL on reset = 0 immediately force FSM = IDLE, last_grant = 1, rd_pending = 0, rd_owner = 0.
REQ-030 SHALL hold gnt*, rvalid*, mem_read, mem_write at 0 and rdata*, mem_address, mem_data_in at 0 during reset.
REQ-031 SHALL drop an in-flight read when reset asserts mid-operation; no rvalid after reset release for it.
REQ-032 SHALL accept requests in the first rising edge cycle after reset deasserts.

Verification
REQ-033 SHALL test: req0 only, we0=1, addr0=5, wdata0=0xAB -> gnt0=1, mem_write=1, mem_address=5, mem_data_in=0xAB same cycle; no rvalid.
REQ-034 SHALL test: req1 only read addr1=5 after above, memory model 1-cycle -> gnt1 in T, rvalid1=1, rdata1=0xAB in T+1, rvalid0=0.
REQ-035 SHALL test: req0=req1=1 reads held 4 cycles after reset -> grants alternate 0,1,0,1; rvalid follows one cycle later with matching owner.
REQ-036 SHALL test: port 1 read with lock1=1, then req0=req1=1 for 3 cycles -> only gnt1 each cycle; after lock1=0 grant, next contended cycle grants port 0.
REQ-037 SHALL test: read granted in T, reset asserted in T+1 -> rvalid0=rvalid1=0, rdata=0, FSM IDLE; after release port 0 wins first contention.
REQ-038 SHALL test: assertion over all cycles -> never gnt0&gnt1, never mem_read&mem_write, rvalidN only one cycle after a read grant to N.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port data memory arbiter: round-robin with lock bursts.
// Single memory command per cycle, one-cycle registered read return.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_memory_arbiter #(
    parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
    parameter int DATA_SIZE    = `DATA_SIZE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic                    lock0,
    input  logic                    lock1,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0]    wdata0,
    input  logic [DATA_SIZE-1:0]    wdata1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    rvalid0,
    output logic                    rvalid1,
    output logic [DATA_SIZE-1:0]    rdata0,
    output logic [DATA_SIZE-1:0]    rdata1,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [DATA_SIZE-1:0]    mem_data_in,
    input  logic [DATA_SIZE-1:0]    mem_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   rd_pending;
    logic   rd_owner;
    logic   pick0;
    logic   pick1;

    // A locked owner is the only candidate; otherwise alternate on contention.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    pick0 = last_grant;
                    pick1 = !last_grant;
                end else begin
                    pick0 = req0;
                    pick1 = req1;
                end
            end
            LOCK0:   pick0 = req0;
            LOCK1:   pick1 = req1;
            default: ;
        endcase
    end

    assign gnt0 = reset && pick0;
    assign gnt1 = reset && pick1;

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        if (gnt0) begin
            mem_read    = !we0;
            mem_write   = we0;
            mem_address = addr0;
            mem_data_in = wdata0;
        end else if (gnt1) begin
            mem_read    = !we1;
            mem_write   = we1;
            mem_address = addr1;
            mem_data_in = wdata1;
        end
    end

    assign rvalid0 = rd_pending && !rd_owner;
    assign rvalid1 = rd_pending && rd_owner;
    assign rdata0  = rvalid0 ? mem_data_out : '0;
    assign rdata1  = rvalid1 ? mem_data_out : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= mem_read;
            rd_owner   <= gnt1;
            if (gnt0)
                last_grant <= 1'b0;
            else if (gnt1)
                last_grant <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (gnt0 && lock0)
                        state <= LOCK0;
                    else if (gnt1 && lock1)
                        state <= LOCK1;
                end
                LOCK0: begin
                    if (!req0 || !lock0)
                        state <= IDLE;
                end
                LOCK1: begin
                    if (!req1 || !lock1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a one-cycle memory model.
// Protocol invariants are also checked on every cycle.
module tb_data_memory_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [256];
    logic          exp_rv0 = 1'b0;
    logic          exp_rv1 = 1'b0;

    data_memory_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_data_out = '0;
    end

    always @(posedge clock) begin
        if (mem_write) mem[mem_address[7:0]] <= mem_data_in;
        if (mem_read) mem_data_out <= mem[mem_address[7:0]];
    end

    // Invariants sampled mid-cycle on every clock
    always @(negedge clock) begin
        if (!reset) begin
            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;
        end else begin
            tests++;
            if (gnt0 && gnt1) begin
                fails++;
                $display("FAIL inv_gnt: gnt0=%b gnt1=%b required not both", gnt0, gnt1);
            end
            tests++;
            if (mem_read && mem_write) begin
                fails++;
                $display("FAIL inv_strobe: rd=%b wr=%b required not both", mem_read, mem_write);
            end
            tests++;
            if (rvalid0 !== exp_rv0 || rvalid1 !== exp_rv1) begin
                fails++;
                $display("FAIL inv_rvalid: got %b%b required %b%b",
                         rvalid0, rvalid1, exp_rv0, exp_rv1);
            end
            exp_rv0 = gnt0 && !we0;
            exp_rv1 = gnt1 && !we1;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        req0 = 1; addr0 = 16'd3; wdata0 = 32'h77;
        @(negedge clock);
        tests++;
        if (gnt0 !== 0 || gnt1 !== 0 || mem_read !== 0 || mem_write !== 0) begin
            fails++;
            $display("FAIL reset_ctl: gnt=%b%b rd=%b wr=%b required 0000",
                     gnt0, gnt1, mem_read, mem_write);
        end
        tests++;
        if (mem_address !== 0 || mem_data_in !== 0 || rvalid0 !== 0 || rvalid1 !== 0
            || rdata0 !== 0 || rdata1 !== 0) begin
            fails++;
            $display("FAIL reset_data: addr=%h din=%h rv=%b%b required 0",
                     mem_address, mem_data_in, rvalid0, rvalid1);
        end
        cyc();
        reset = 1;
        @(negedge clock);
        tests++;
        if (gnt0 !== 1 || mem_read !== 1 || mem_address !== 16'd3) begin
            fails++;
            $display("FAIL reset_first_req: gnt0=%b rd=%b addr=%h required 1 1 3",
                     gnt0, mem_read, mem_address);
        end
        cyc();
        idle_inputs();
        @(negedge clock);
        tests++;
        if (rvalid0 !== 1 || rdata0 !== 0) begin
            fails++;
            $display("FAIL reset_first_rd: rvalid0=%b rdata0=%h required 1 0", rvalid0, rdata0);
        end
        cyc();
    endtask

    task automatic test_write();
        req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 32'hAB;
        @(negedge clock);
        tests++;
        if (gnt0 !== 1 || gnt1 !== 0 || mem_write !== 1 || mem_read !== 0) begin
            fails++;
            $display("FAIL write_ctl: gnt=%b%b wr=%b rd=%b required 10 1 0",
                     gnt0, gnt1, mem_write, mem_read);
        end
        tests++;
        if (mem_address !== 16'd5 || mem_data_in !== 32'hAB) begin
            fails++;
            $display("FAIL write_data: addr=%h din=%h required 5 ab", mem_address, mem_data_in);
        end
        cyc();
        idle_inputs();
        @(negedge clock);
        tests++;
        if (rvalid0 !== 0 || rvalid1 !== 0) begin
            fails++;
            $display("FAIL write_norv: rvalid=%b%b required 00", rvalid0, rvalid1);
        end
        cyc();
    endtask

    task automatic test_read_port1();
        req1 = 1; addr1 = 16'd5;
        @(negedge clock);
        tests++;
        if (gnt1 !== 1 || gnt0 !== 0 || mem_read !== 1 || mem_address !== 16'd5) begin
            fails++;
            $display("FAIL read1_gnt: gnt=%b%b rd=%b addr=%h required 01 1 5",
                     gnt0, gnt1, mem_read, mem_address);
        end
        cyc();
        idle_inputs();
        @(negedge clock);
        tests++;
        if (rvalid1 !== 1 || rdata1 !== 32'hAB || rvalid0 !== 0 || rdata0 !== 0) begin
            fails++;
            $display("FAIL read1_ret: rv=%b%b rdata1=%h rdata0=%h required 01 ab 0",
                     rvalid0, rvalid1, rdata1, rdata0);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        req0 = 1; we0 = 1; addr0 = 16'd10; wdata0 = 32'h11;
        cyc();
        addr0 = 16'd20; wdata0 = 32'h22;
        cyc();
        idle_inputs();
        reset = 0;
        cyc();
        reset = 1;
        req0 = 1; req1 = 1; addr0 = 16'd10; addr1 = 16'd20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            tests++;
            if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL rr_gnt%0d: gnt=%b%b required port %0d", k, gnt0, gnt1, k % 2);
            end
            if (k > 0) begin
                e0 = (k % 2 == 1) ? 32'h11 : 32'h0;
                e1 = (k % 2 == 0) ? 32'h22 : 32'h0;
                tests++;
                if (rdata0 !== e0 || rdata1 !== e1) begin
                    fails++;
                    $display("FAIL rr_data%0d: rdata0=%h rdata1=%h required %h %h",
                             k, rdata0, rdata1, e0, e1);
                end
            end
            cyc();
        end
        idle_inputs();
        @(negedge clock);
        tests++;
        if (rvalid1 !== 1 || rdata1 !== 32'h22) begin
            fails++;
            $display("FAIL rr_last: rvalid1=%b rdata1=%h required 1 22", rvalid1, rdata1);
        end
        cyc();
    endtask

    task automatic test_lock();
        req1 = 1; lock1 = 1; addr1 = 16'd20;
        @(negedge clock);
        tests++;
        if (gnt1 !== 1) begin
            fails++;
            $display("FAIL lock_first: gnt1=%b required 1", gnt1);
        end
        cyc();
        req0 = 1; addr0 = 16'd10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            tests++;
            if (gnt1 !== 1 || gnt0 !== 0 || mem_address !== 16'd20) begin
                fails++;
                $display("FAIL lock_hold%0d: gnt=%b%b addr=%h required 01 20",
                         k, gnt0, gnt1, mem_address);
            end
            cyc();
        end
        lock1 = 0;
        @(negedge clock);
        tests++;
        if (gnt1 !== 1 || gnt0 !== 0) begin
            fails++;
            $display("FAIL lock_release: gnt=%b%b required 01", gnt0, gnt1);
        end
        cyc();
        @(negedge clock);
        tests++;
        if (gnt0 !== 1 || gnt1 !== 0) begin
            fails++;
            $display("FAIL lock_after: gnt=%b%b required 10", gnt0, gnt1);
        end
        cyc();
        req1 = 0; lock0 = 1;
        cyc();
        req0 = 0; lock0 = 0; req1 = 1;
        @(negedge clock);
        tests++;
        if (gnt0 !== 0 || gnt1 !== 0 || mem_read !== 0 || mem_address !== 0) begin
            fails++;
            $display("FAIL lock0_exit: gnt=%b%b rd=%b addr=%h required 00 0 0",
                     gnt0, gnt1, mem_read, mem_address);
        end
        cyc();
        @(negedge clock);
        tests++;
        if (gnt1 !== 1 || gnt0 !== 0) begin
            fails++;
            $display("FAIL lock0_idle: gnt=%b%b required 01", gnt0, gnt1);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        req0 = 1; addr0 = 16'd10;
        cyc();
        req0 = 0; req1 = 1; we1 = 1; addr1 = 16'd30; wdata1 = 32'h55;
        @(negedge clock);
        tests++;
        if (gnt1 !== 1 || mem_write !== 1 || mem_data_in !== 32'h55
            || rvalid0 !== 1 || rdata0 !== 32'h11) begin
            fails++;
            $display("FAIL b2b_wr_rd: gnt1=%b wr=%b din=%h rv0=%b rdata0=%h required 1 1 55 1 11",
                     gnt1, mem_write, mem_data_in, rvalid0, rdata0);
        end
        cyc();
        idle_inputs();
        req0 = 1; addr0 = 16'd30;
        cyc();
        idle_inputs();
        @(negedge clock);
        tests++;
        if (rvalid0 !== 1 || rdata0 !== 32'h55) begin
            fails++;
            $display("FAIL b2b_readback: rvalid0=%b rdata0=%h required 1 55", rvalid0, rdata0);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        req0 = 1; addr0 = 16'd10;
        cyc();
        reset = 0;
        req1 = 1; addr1 = 16'd20;
        @(negedge clock);
        tests++;
        if (rvalid0 !== 0 || rvalid1 !== 0 || rdata0 !== 0 || rdata1 !== 0) begin
            fails++;
            $display("FAIL mid_drop: rv=%b%b rdata0=%h rdata1=%h required 0",
                     rvalid0, rvalid1, rdata0, rdata1);
        end
        tests++;
        if (gnt0 !== 0 || gnt1 !== 0 || mem_read !== 0 || mem_address !== 0) begin
            fails++;
            $display("FAIL mid_quiet: gnt=%b%b rd=%b addr=%h required 0",
                     gnt0, gnt1, mem_read, mem_address);
        end
        cyc();
        reset = 1;
        @(negedge clock);
        tests++;
        if (gnt0 !== 1 || gnt1 !== 0) begin
            fails++;
            $display("FAIL mid_first: gnt=%b%b required 10", gnt0, gnt1);
        end
        cyc();
        idle_inputs();
        cyc();
        cyc();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_write();
        test_read_port1();
        test_round_robin();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
